ram_dualport_param: RTL and testbench

//   Parametrised true dual-port synchronous RAM with separate write/read data buses per port.

---
 rtl/ram_dualport_param.sv | 200 ++++++++++++++++++++
 tb/tb_ram_dualport_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dualport_param.sv
// True dual-port synchronous RAM with power-up clear sequencer, per-port read-during-write
// selection, cross-port collision arbitration and an optional output register stage.
module ram_dualport_param #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 4,
  parameter int OUT_REG       = 0,
  parameter int RDW_MODE      = 0,
  parameter int WR_PRIORITY   = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_a,
  input  logic              wr_en_a,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              cs_b,
  input  logic              wr_en_b,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              collision,
  output logic              init_busy,
  output logic              o_dbg_state
);

  // Handshake: a read is accepted in any RUN cycle with cs_x & rd_en_x (no back-pressure);
  // rvalid_x pulses exactly once per accepted read, OUT_REG+1 edges later, with rdata_x.
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic WR_FIRST = (RDW_MODE != 0);
  localparam logic B_WINS   = (WR_PRIORITY != 0);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic              w_clr_we;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_wr_a;
  logic              w_rd_a;
  logic              w_wr_b;
  logic              w_rd_b;
  logic              w_same;
  logic              w_commit_a;
  logic              w_commit_b;
  logic              w_coll;
  logic [DATA_W-1:0] w_rword_a;
  logic [DATA_W-1:0] w_rword_b;

  logic              r_s1_vld_a;
  logic              r_s1_vld_b;
  logic [DATA_W-1:0] r_s1_data_a;
  logic [DATA_W-1:0] r_s1_data_b;
  logic              r_collision;

  // ---------------------------------------------------------------- clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_we = 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_run       = (r_state == ST_RUN);
  assign init_busy   = (r_state == ST_INIT);
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------- access qualification
  assign w_wr_a = w_run & cs_a & wr_en_a;
  assign w_rd_a = w_run & cs_a & rd_en_a;
  assign w_wr_b = w_run & cs_b & wr_en_b;
  assign w_rd_b = w_run & cs_b & rd_en_b;
  assign w_same = (addr_a == addr_b);

  // A same-address dual write keeps only the priority port's data.
  assign w_commit_a = w_wr_a & ~(w_wr_b & w_same & B_WINS);
  assign w_commit_b = w_wr_b & ~(w_wr_a & w_same & ~B_WINS);

  assign w_coll = w_same & ((w_wr_a & (w_wr_b | w_rd_b)) | (w_wr_b & w_rd_a));

  // Across ports a reader always sees the pre-write word; bypass is same-port only.
  assign w_rword_a = (WR_FIRST && w_wr_a) ? wdata_a : r_mem[addr_a];
  assign w_rword_b = (WR_FIRST && w_wr_b) ? wdata_b : r_mem[addr_b];

  // ---------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end
    if (w_commit_a) begin
      r_mem[addr_a] <= wdata_a;
    end
    if (w_commit_b) begin
      r_mem[addr_b] <= wdata_b;
    end
  end

  // ---------------------------------------------------------------- first read stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld_a  <= 1'b0;
      r_s1_vld_b  <= 1'b0;
      r_s1_data_a <= '0;
      r_s1_data_b <= '0;
      r_collision <= 1'b0;
    end else begin
      r_s1_vld_a  <= w_rd_a;
      r_s1_vld_b  <= w_rd_b;
      r_collision <= w_coll;
      if (w_rd_a) begin
        r_s1_data_a <= w_rword_a;
      end
      if (w_rd_b) begin
        r_s1_data_b <= w_rword_b;
      end
    end
  end

  assign collision = r_collision;

  // ---------------------------------------------------------------- optional output stage
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_s2_vld_a;
      logic              r_s2_vld_b;
      logic [DATA_W-1:0] r_s2_data_a;
      logic [DATA_W-1:0] r_s2_data_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_vld_a  <= 1'b0;
          r_s2_vld_b  <= 1'b0;
          r_s2_data_a <= '0;
          r_s2_data_b <= '0;
        end else begin
          r_s2_vld_a <= r_s1_vld_a;
          r_s2_vld_b <= r_s1_vld_b;
          if (r_s1_vld_a) begin
            r_s2_data_a <= r_s1_data_a;
          end
          if (r_s1_vld_b) begin
            r_s2_data_b <= r_s1_data_b;
          end
        end
      end

      assign rdata_a  = r_s2_data_a;
      assign rvalid_a = r_s2_vld_a;
      assign rdata_b  = r_s2_data_b;
      assign rvalid_b = r_s2_vld_b;
    end else begin : g_no_out_reg
      assign rdata_a  = r_s1_data_a;
      assign rvalid_a = r_s1_vld_a;
      assign rdata_b  = r_s1_data_b;
      assign rvalid_b = r_s1_vld_b;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dualport_param.sv
// Bench for ram_dualport_param: directed vector table, clear/reset sequences and random
// traffic, all checked against an array-based reference memory.
module tb_ram_dualport_param;

  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 4;
  localparam int OUT_REG       = 0;
  localparam int RDW_MODE      = 0;
  localparam int WR_PRIORITY   = 0;
  localparam int INIT_ON_RESET = 1;
  localparam int DEPTH         = 1 << ADDR_W;
  localparam int LAT           = OUT_REG + 1;
  localparam int NV            = 15;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } port_op_t;

  typedef struct packed {
    port_op_t          a;
    port_op_t          b;
    logic              exp_vld_a;
    logic [DATA_W-1:0] exp_da;
    logic              exp_vld_b;
    logic [DATA_W-1:0] exp_db;
    logic              exp_coll;
  } vec_t;

  // ---------------------------------------------------------------- clock / reset / DUT
  logic              clk;
  logic              rst_n;
  logic              cs_a, wr_en_a, rd_en_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a, rdata_a;
  logic              rvalid_a;
  logic              cs_b, wr_en_b, rd_en_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b, rdata_b;
  logic              rvalid_b;
  logic              collision, init_busy, dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_dualport_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(OUT_REG), .RDW_MODE(RDW_MODE),
    .WR_PRIORITY(WR_PRIORITY), .INIT_ON_RESET(INIT_ON_RESET)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cs_a(cs_a), .wr_en_a(wr_en_a), .rd_en_a(rd_en_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .cs_b(cs_b), .wr_en_b(wr_en_b), .rd_en_b(rd_en_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .collision(collision), .init_busy(init_busy), .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- reference model + scoreboard
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                init_left;
  logic [DATA_W-1:0] exp_q_a[$];
  logic [DATA_W-1:0] exp_q_b[$];
  logic              vld_q_a[$];
  logic              vld_q_b[$];
  logic [DATA_W-1:0] last_a, last_b;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic port_op_t op(input logic cs, input logic we, input logic re,
                                  input int addr, input int wd);
    port_op_t o;
    o.cs   = cs;
    o.we   = we;
    o.re   = re;
    o.addr = ADDR_W'(addr);
    o.wd   = DATA_W'(wd);
    return o;
  endfunction

  function automatic port_op_t idle_op();
    return op(1'b0, 1'b0, 1'b0, 0, 0);
  endfunction

  // One clock cycle: drive both ports, advance the model, compare all outputs after the edge.
  task automatic step(input port_op_t a, input port_op_t b);
    logic              busy, wa, wb, ra, rb, same, coll, va, vb;
    logic [DATA_W-1:0] da, db;
    cs_a = a.cs; wr_en_a = a.we; rd_en_a = a.re; addr_a = a.addr; wdata_a = a.wd;
    cs_b = b.cs; wr_en_b = b.we; rd_en_b = b.re; addr_b = b.addr; wdata_b = b.wd;
    busy = (init_left > 0);
    wa   = !busy && a.cs && a.we;
    ra   = !busy && a.cs && a.re;
    wb   = !busy && b.cs && b.we;
    rb   = !busy && b.cs && b.re;
    same = (a.addr == b.addr);
    da   = (wa && RDW_MODE == 1) ? a.wd : ref_mem[a.addr];
    db   = (wb && RDW_MODE == 1) ? b.wd : ref_mem[b.addr];
    coll = same && ((wa && (wb || rb)) || (wb && ra));
    if (wa && wb && same) begin
      ref_mem[a.addr] = (WR_PRIORITY == 1) ? b.wd : a.wd;
    end else begin
      if (wa) ref_mem[a.addr] = a.wd;
      if (wb) ref_mem[b.addr] = b.wd;
    end
    if (busy) init_left--;
    exp_q_a.push_back(da);
    vld_q_a.push_back(ra);
    exp_q_b.push_back(db);
    vld_q_b.push_back(rb);
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
    if (vld_q_a.size() == LAT) begin
      va = vld_q_a.pop_front();
      da = exp_q_a.pop_front();
      if (va) last_a = da;
    end
    if (vld_q_b.size() == LAT) begin
      vb = vld_q_b.pop_front();
      db = exp_q_b.pop_front();
      if (vb) last_b = db;
    end
    check("rvalid_a", rvalid_a, va);
    check("rdata_a", rdata_a, last_a);
    check("rvalid_b", rvalid_b, vb);
    check("rdata_b", rdata_b, last_b);
    check("collision", collision, coll);
    check("init_busy", init_busy, init_left > 0);
  endtask

  // Asserts rst_n asynchronously mid-cycle; must be called just after a falling edge.
  task automatic do_reset();
    cs_a = 0; wr_en_a = 0; rd_en_a = 0; addr_a = '0; wdata_a = '0;
    cs_b = 0; wr_en_b = 0; rd_en_b = 0; addr_b = '0; wdata_b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdata_a", rdata_a, 0);
    check("rst_rdata_b", rdata_b, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    check("rst_collision", collision, 0);
    check("rst_init_busy", init_busy, INIT_ON_RESET);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    init_left = (INIT_ON_RESET != 0) ? DEPTH : 0;
    if (INIT_ON_RESET != 0) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end
    exp_q_a.delete(); vld_q_a.delete();
    exp_q_b.delete(); vld_q_b.delete();
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test sequence
  vec_t     vecs [NV];
  port_op_t ra_op, rb_op;

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    init_left = 0;
    @(negedge clk);

    // Clear after reset, then every address reads zero on each port.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(idle_op(), idle_op());
    for (int i = 0; i < DEPTH; i++) step(op(1, 0, 1, i, 0), op(1, 0, 1, DEPTH - 1 - i, 0));
    for (int k = 1; k < LAT; k++) step(idle_op(), idle_op());

    // Directed vectors: {port A op, port B op, expected read results, expected collision}.
    vecs[0]  = '{op(1,1,0,3,8'h5A), idle_op(),         0, 8'h00, 0, 8'h00, 0};
    vecs[1]  = '{idle_op(),         op(1,0,1,3,0),     0, 8'h00, 1, 8'h5A, 0};
    vecs[2]  = '{op(1,1,0,7,8'h11), op(1,1,0,7,8'h22), 0, 8'h00, 0, 8'h00, 1};
    vecs[3]  = '{op(1,0,1,7,0),     idle_op(),
                 1, (WR_PRIORITY == 1) ? 8'h22 : 8'h11, 0, 8'h00, 0};
    vecs[4]  = '{op(1,1,0,9,8'h33), idle_op(),         0, 8'h00, 0, 8'h00, 0};
    vecs[5]  = '{op(1,1,0,9,8'h44), op(1,0,1,9,0),     0, 8'h00, 1, 8'h33, 1};
    vecs[6]  = '{idle_op(),         op(1,0,1,9,0),     0, 8'h00, 1, 8'h44, 0};
    vecs[7]  = '{op(1,1,0,2,8'hAA), idle_op(),         0, 8'h00, 0, 8'h00, 0};
    vecs[8]  = '{op(1,1,1,2,8'hBB), idle_op(),
                 1, (RDW_MODE == 1) ? 8'hBB : 8'hAA, 0, 8'h00, 0};
    vecs[9]  = '{op(1,0,1,2,0),     idle_op(),         1, 8'hBB, 0, 8'h00, 0};
    vecs[10] = '{op(1,0,1,3,0),     op(1,0,1,3,0),     1, 8'h5A, 1, 8'h5A, 0};
    vecs[11] = '{op(1,1,0,4,8'h01), op(1,1,0,5,8'h02), 0, 8'h00, 0, 8'h00, 0};
    vecs[12] = '{op(1,0,1,5,0),     op(1,0,1,4,0),     1, 8'h02, 1, 8'h01, 0};
    vecs[13] = '{op(0,1,1,3,8'hFF), op(0,1,1,3,8'hEE), 0, 8'h00, 0, 8'h00, 0};
    vecs[14] = '{op(1,1,0,6,8'h66), op(1,0,1,3,0),     0, 8'h00, 1, 8'h5A, 0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_collision", i), collision, vecs[i].exp_coll);
      for (int k = 1; k < LAT; k++) step(idle_op(), idle_op());
      check($sformatf("vec%0d_rvalid_a", i), rvalid_a, vecs[i].exp_vld_a);
      check($sformatf("vec%0d_rvalid_b", i), rvalid_b, vecs[i].exp_vld_b);
      if (vecs[i].exp_vld_a) check($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].exp_da);
      if (vecs[i].exp_vld_b) check($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].exp_db);
    end

    // Back-to-back reads on both ports while port A also writes behind them.
    for (int i = 0; i < 8; i++) step(op(1, 1, 1, i + 8, 8'hC0 + i), op(1, 0, 1, i, 0));

    // Random traffic, addresses biased toward a small window so conflicts are frequent.
    for (int i = 0; i < 500; i++) begin
      ra_op.cs   = ($urandom_range(0, 7) != 0);
      ra_op.we   = $urandom_range(0, 1);
      ra_op.re   = $urandom_range(0, 1);
      ra_op.addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 3))
                                               : ADDR_W'($urandom_range(0, DEPTH - 1));
      ra_op.wd   = DATA_W'($urandom_range(1, 255));
      rb_op.cs   = ($urandom_range(0, 7) != 0);
      rb_op.we   = $urandom_range(0, 1);
      rb_op.re   = $urandom_range(0, 1);
      rb_op.addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 3))
                                               : ADDR_W'($urandom_range(0, DEPTH - 1));
      rb_op.wd   = DATA_W'($urandom_range(1, 255));
      step(ra_op, rb_op);
    end
    for (int i = 0; i < DEPTH; i++) step(op(1, 1, 0, i, 8'h80 + i), idle_op());

    // Reset mid-clear: counter restarts, writes during the clear are lost.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step(op(1, 1, 0, 5, 8'h77), op(1, 1, 1, 6, 8'h78));
      else step(idle_op(), idle_op());
    end
    check("midinit_busy", init_busy, 1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) step(op(1, 1, 0, 6, 8'h99), op(1, 0, 1, 6, 0));
      else step(idle_op(), idle_op());
    end
    check("init_done", init_busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(op(1, 0, 1, i, 0), op(1, 0, 1, DEPTH - 1 - i, 0));
      for (int k = 1; k < LAT; k++) step(idle_op(), idle_op());
      check($sformatf("clr_rdata_a_%0d", i), rdata_a, 0);
      check($sformatf("clr_rdata_b_%0d", i), rdata_b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
